// File: rtl/ddr3_rd_return_pkg.sv
// Shared widths and helpers for the DDR3 read-return block.
//   DDR_APP_DW : DDR3 application data width (one rd_data beat)
//   PIX_W      : width of one rebuilt pixel word
//   PIX_AW     : pixel address width
//   OUT_W      : width of one result entry {addr, pixel}
//   clog2()    : ceiling log2, usable in constant expressions
package ddr3_rd_return_pkg;

    localparam int DDR_APP_DW = 64;
    localparam int PIX_W      = 48;
    localparam int PIX_AW     = 16;
    localparam int OUT_W      = PIX_AW + PIX_W;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ddr3_rd_return_if.sv
// Bus bundle between the read-return block, the DDR3 top and the pixel pipeline.
//   req_*      : pixel read requests from the pipeline (valid/ready)
//   rd_en/addr : read command toward the DDR3 top
//   rd_data_*  : returned app_rd_data beats (cannot be stalled)
//   pix_*      : in-order {addr, pixel} results to the pipeline (valid/ready)
// Modport slave is the read-return block's view, master is the surrounding system's view.
interface ddr3_rd_return_if import ddr3_rd_return_pkg::*; ();

    logic                  req_valid;
    logic [PIX_AW-1:0]     req_addr;
    logic                  req_ready;
    logic                  rd_en;
    logic [PIX_AW-1:0]     rd_addr;
    logic                  rd_data_valid;
    logic                  rd_data_end;
    logic [DDR_APP_DW-1:0] rd_data;
    logic                  pix_valid;
    logic                  pix_ready;
    logic [PIX_W-1:0]      pix_data;
    logic [PIX_AW-1:0]     pix_addr;

    modport slave (
        input  req_valid, req_addr, rd_data_valid, rd_data_end, rd_data, pix_ready,
        output req_ready, rd_en, rd_addr, pix_valid, pix_data, pix_addr
    );

    modport master (
        output req_valid, req_addr, rd_data_valid, rd_data_end, rd_data, pix_ready,
        input  req_ready, rd_en, rd_addr, pix_valid, pix_data, pix_addr
    );

endinterface

// File: rtl/ddr3_rd_return_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   wr_en/data : write port; the write lands on the clock edge
//   rd_en      : pop the head entry (ignored when empty)
//   rd_data    : head entry, valid whenever !empty
//   full/empty/count : occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo import ddr3_rd_return_pkg::*; #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [clog2(DEPTH):0] count
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_wr;
    logic             do_rd;

    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage has no reset so it can map onto RAM resources.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr_q];
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;

    // Upstream credit accounting guarantees a write never meets a full FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && full));

endmodule

// File: rtl/ddr3_rd_return.sv
// DDR3 read-return path: issues tagged pixel reads and rebuilds one pixel per burst.
//   clk, rst_n  : controller user clock, synchronous active-low reset
//   calib_done  : DDR3 calibration complete; gates new requests only
//   bus         : request / read-command / read-data / result bundle (slave view)
//   in_flight   : requests issued whose burst has not completed yet
//   err_unexp   : sticky, a beat arrived with no outstanding request
//   err_burst   : sticky, rd_data_end disagreed with the beat count
// Read data cannot be stalled, so a request is only accepted while the sum of in-flight
// bursts and buffered results leaves room for its result in the output FIFO.
module ddr3_rd_return import ddr3_rd_return_pkg::*; #(
    parameter int DEPTH    = 16,
    parameter int BEATS    = 2,
    parameter int WORD_SEL = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  calib_done,
    ddr3_rd_return_if.slave       bus,
    output logic [clog2(DEPTH):0] in_flight,
    output logic                  err_unexp,
    output logic                  err_burst
);

    localparam int CW = clog2(DEPTH) + 1;
    localparam int BW = (BEATS > 1) ? clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [BW-1:0] SEL_BEAT  = BW'(WORD_SEL);

    // Tag FIFO: addresses of requests awaiting their burst.
    logic              tag_push;
    logic              tag_pop;
    logic [PIX_AW-1:0] tag_addr;
    logic              tag_empty;
    logic              unused_tag_full;
    logic [CW-1:0]     tag_count;

    // Output FIFO: completed {addr, pixel} results in request order.
    logic              out_push;
    logic              out_pop;
    logic [OUT_W-1:0]  out_wdata;
    logic [OUT_W-1:0]  out_rdata;
    logic              out_empty;
    logic              unused_out_full;
    logic [CW-1:0]     out_count;

    logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
    logic [PIX_W-1:0]  cap_q, cap_d;
    logic              err_unexp_q, err_unexp_d;
    logic              err_burst_q, err_burst_d;

    logic [CW:0]       used;
    logic              req_ready_w;
    logic              beat_hit;
    logic [PIX_W-1:0]  pixel;
    logic              unused_rd_hi;

    assign unused_rd_hi = ^bus.rd_data[DDR_APP_DW-1:PIX_W];

    // Credits: every in-flight burst already owns a slot in the output FIFO.
    assign used        = {1'b0, tag_count} + {1'b0, out_count};
    assign req_ready_w = rst_n & calib_done & (used < (CW+1)'(DEPTH));
    assign tag_push    = bus.req_valid & req_ready_w;

    assign bus.req_ready = req_ready_w;
    assign bus.rd_en     = tag_push;
    assign bus.rd_addr   = bus.req_addr;

    // A beat is only meaningful when a tag is waiting for it.
    assign beat_hit = bus.rd_data_valid & ~tag_empty;

    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        cap_d       = cap_q;
        err_unexp_d = err_unexp_q;
        err_burst_d = err_burst_q;
        tag_pop     = 1'b0;
        out_push    = 1'b0;
        pixel       = cap_q;

        if (bus.rd_data_valid && tag_empty) begin
            err_unexp_d = 1'b1;
        end

        if (beat_hit) begin
            // The selected beat bypasses the capture register so WORD_SEL may be the last beat.
            if (beat_cnt_q == SEL_BEAT) begin
                cap_d = bus.rd_data[PIX_W-1:0];
                pixel = bus.rd_data[PIX_W-1:0];
            end
            if (beat_cnt_q == LAST_BEAT) begin
                out_push   = 1'b1;
                tag_pop    = 1'b1;
                beat_cnt_d = '0;
                if (!bus.rd_data_end) begin
                    err_burst_d = 1'b1;
                end
            end else if (bus.rd_data_end) begin
                // Short burst: its pixel is incomplete, so the tag is discarded.
                err_burst_d = 1'b1;
                tag_pop     = 1'b1;
                beat_cnt_d  = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt_q  <= '0;
            cap_q       <= '0;
            err_unexp_q <= 1'b0;
            err_burst_q <= 1'b0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            cap_q       <= cap_d;
            err_unexp_q <= err_unexp_d;
            err_burst_q <= err_burst_d;
        end
    end

    assign out_wdata = {tag_addr, pixel};
    assign out_pop   = ~out_empty & bus.pix_ready;

    sync_fifo #(
        .WIDTH (PIX_AW),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (tag_push),
        .wr_data (bus.req_addr),
        .rd_en   (tag_pop),
        .rd_data (tag_addr),
        .full    (unused_tag_full),
        .empty   (tag_empty),
        .count   (tag_count)
    );

    sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_out_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (out_push),
        .wr_data (out_wdata),
        .rd_en   (out_pop),
        .rd_data (out_rdata),
        .full    (unused_out_full),
        .empty   (out_empty),
        .count   (out_count)
    );

    // Outputs read as zero while nothing is buffered (stale RAM contents never leak out).
    assign bus.pix_valid = ~out_empty;
    assign bus.pix_data  = out_empty ? '0 : out_rdata[PIX_W-1:0];
    assign bus.pix_addr  = out_empty ? '0 : out_rdata[OUT_W-1:PIX_W];

    assign in_flight = tag_count;
    assign err_unexp = err_unexp_q;
    assign err_burst = err_burst_q;

endmodule
